// File: rtl/sseg_scan_driver_pkg.sv
// Segment patterns (a..g, active-low, a in the leftmost bit), conversion FSM states,
// and helpers shared by the seven-segment scan driver and its BCD converter.
package sseg_scan_driver_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // ceil(data_w * log10(2)) + 1, in fixed point so it folds to a constant
    function automatic int bcd_digits(input int data_w);
        return (data_w * 30103 + 99999) / 100000 + 1;
    endfunction

    function automatic seg_t seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/sseg_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble: start loads bin, then DATA_W add-3/shift cycles; done is high
// during the final shift cycle and bcd holds the result until the next start.
module bin2bcd_seq #(
    parameter int DATA_W     = 16,
    parameter int BCD_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic [BCD_DIGITS*4-1:0] bcd,
    output logic                    done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0]       shift_reg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    running;
    logic [BCD_DIGITS*4-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign done = running && (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            running   <= 1'b0;
        end else if (start) begin
            shift_reg <= bin;
            bcd       <= '0;
            bit_cnt   <= '0;
            running   <= 1'b1;
        end else if (running) begin
            bcd       <= {bcd_adj[BCD_DIGITS*4-2:0], shift_reg[DATA_W-1]};
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment driver: binary -> BCD shadow digits (DATA_W+2 clks, atomic commit),
// scanned onto active-low segment/anode pins; outputs are registered one clk behind the scan index.
module sseg_scan_driver
    import sseg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int DATA_W     = 16,
    parameter int PRESCALE   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     num,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [0:6]            sseg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_DIGITS = bcd_digits(DATA_W);
    localparam int PAD_DIGITS = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;
    localparam int PS_W       = $clog2(PRESCALE);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PS_W-1:0]         ps_cnt;
    logic                    tick;
    logic [IDX_W-1:0]        scan_idx;

    conv_state_t             state, state_nxt;
    logic                    conv_start;
    logic                    conv_done;
    logic [DATA_W-1:0]       last_num;
    logic [BCD_DIGITS*4-1:0] bcd;
    logic [PAD_DIGITS*4-1:0] bcd_ext;
    logic                    ovf_nxt;
    logic [3:0]              shadow [NUM_DIGITS];

    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   lz_blank;
    seg_t                    sseg_nxt;
    logic                    dp_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_cnt   <= '0;
            scan_idx <= '0;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
            if (tick) begin
                scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end
        end
    end

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (num),
        .bcd   (bcd),
        .done  (conv_done)
    );

    always_comb begin
        state_nxt  = state;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (num != last_num) begin
                    conv_start = 1'b1;
                    state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (conv_done) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Converter width is independent of the display width; any digit past the display overflows
    always_comb begin
        bcd_ext = (PAD_DIGITS*4)'(bcd);
        ovf_nxt = 1'b0;
        for (int i = NUM_DIGITS; i < PAD_DIGITS; i++) begin
            if (bcd_ext[i*4 +: 4] != 4'd0) begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            last_num <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 4'd0;
            end
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            if (conv_start) begin
                last_num <= num;
            end
            if (state == ST_COMMIT) begin
                overflow <= ovf_nxt;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    shadow[i] <= bcd_ext[i*4 +: 4];
                end
            end
        end
    end

    // Digit i is a leading zero when it and every more significant digit are zero
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (shadow[i] == 4'd0);
            lz_blank[i] = blank_lz && zero_above && (i != 0);
        end
    end

    always_comb begin
        an_nxt = ~(NUM_DIGITS'(1) << scan_idx);
        if (overflow) begin
            sseg_nxt = SEG_DASH;
            dp_nxt   = 1'b1;
        end else begin
            sseg_nxt = lz_blank[scan_idx] ? SEG_BLANK : seg_decode(shadow[scan_idx]);
            dp_nxt   = ~dp_mask[scan_idx];
        end
    end

    // Anode and segments share one register stage so they switch on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            an   <= '1;
            sseg <= SEG_BLANK;
            dp   <= 1'b1;
        end else begin
            an   <= an_nxt;
            sseg <= sseg_nxt;
            dp   <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: a 5-digit and a 4-digit instance share num, checked against
// a decimal-arithmetic reference of what each anode slot must show.
module tb_sseg_scan_driver;

    localparam int PS = 4;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b1111110;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] num = 16'd0;
    logic        blank_lz = 1'b0;
    logic [4:0]  dp_mask = 5'd0;
    logic [0:6]  sseg, sseg4;
    logic        dp, dp4, busy, busy4, overflow, overflow4;
    logic [4:0]  an;
    logic [3:0]  an4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.NUM_DIGITS(5), .DATA_W(16), .PRESCALE(PS)) u_dut (
        .clk(clk), .rst(rst), .num(num), .blank_lz(blank_lz), .dp_mask(dp_mask),
        .sseg(sseg), .dp(dp), .an(an), .busy(busy), .overflow(overflow)
    );

    sseg_scan_driver #(.NUM_DIGITS(4), .DATA_W(16), .PRESCALE(PS)) u_dut4 (
        .clk(clk), .rst(rst), .num(num), .blank_lz(blank_lz), .dp_mask(dp_mask[3:0]),
        .sseg(sseg4), .dp(dp4), .an(an4), .busy(busy4), .overflow(overflow4)
    );

    typedef struct {
        int              v;
        bit              blz;
        logic [4:0]      mask;
        logic [4:0][6:0] seg;
        bit              ovf4;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return S0;  1: return S1;  2: return S2;  3: return S3;  4: return S4;
            5: return S5;  6: return S6;  7: return S7;  8: return S8;  9: return S9;
            default: return SB;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k, input bit blz, input int nd);
        if (v >= p10(nd)) return SD;
        if (blz && k > 0 && v < p10(k)) return SB;
        return ref_seg((v / p10(k)) % 10);
    endfunction

    function automatic bit exp_dp(input int v, input int k, input logic [4:0] mask, input int nd);
        if (v >= p10(nd)) return 1'b1;
        return ~mask[k];
    endfunction

    function automatic int an_index(input logic [4:0] a, input int nd);
        int idx = -1;
        int zeros = 0;
        for (int i = 0; i < nd; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros != 1) return -1;
        return idx;
    endfunction

    task automatic settle();
        int i = 0;
        while ((busy || busy4) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("settle_busy", {30'd0, busy, busy4}, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic apply(input int v, input bit blz, input logic [4:0] mask);
        @(negedge clk);
        num      = 16'(v);
        blank_lz = blz;
        dp_mask  = mask;
        @(negedge clk);
        settle();
    endtask

    // Watches two full refresh rounds on both instances against the reference
    task automatic check_scan(input int v, input bit blz, input logic [4:0] mask);
        int         prev [2];
        int         run [2];
        bit         first [2];
        logic [4:0] seen;
        int         nd, k;
        logic [4:0] a;
        logic [6:0] s;
        logic       p;
        prev  = '{-1, -1};
        run   = '{0, 0};
        first = '{1'b1, 1'b1};
        seen  = '0;
        for (int c = 0; c < 2 * 5 * PS + 2; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                nd = (d == 0) ? 5 : 4;
                a  = (d == 0) ? an : {1'b1, an4};
                s  = (d == 0) ? sseg : sseg4;
                p  = (d == 0) ? dp : dp4;
                k  = an_index(a, nd);
                check(d == 0 ? "an_onehot5" : "an_onehot4", {31'd0, k >= 0}, 1);
                if (k < 0) continue;
                check(d == 0 ? "sseg5" : "sseg4", {25'd0, s}, {25'd0, exp_seg(v, k, blz, nd)});
                check(d == 0 ? "dp5" : "dp4", {31'd0, p}, {31'd0, exp_dp(v, k, mask, nd)});
                if (k == prev[d]) begin
                    run[d]++;
                end else begin
                    if (prev[d] >= 0) begin
                        check("scan_order", k, (prev[d] + 1) % nd);
                        if (!first[d]) check("dwell", run[d], PS);
                        first[d] = 1'b0;
                    end
                    prev[d] = k;
                    run[d]  = 1;
                end
                if (d == 0) seen[k] = 1'b1;
            end
        end
        check("all_digits", {27'd0, seen}, 32'h1f);
        check("overflow5", {31'd0, overflow}, {31'd0, v >= 100000});
        check("overflow4", {31'd0, overflow4}, {31'd0, v >= 10000});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        int   cnt, gap, i, k;
        int   v;
        bit   blz;
        logic [4:0] mask;

        tbl[0] = '{4321,  1'b0, 5'b00000, {S0, S4, S3, S2, S1}, 1'b0};
        tbl[1] = '{65535, 1'b0, 5'b00000, {S6, S5, S5, S3, S5}, 1'b1};
        tbl[2] = '{7,     1'b1, 5'b00000, {SB, SB, SB, SB, S7}, 1'b0};
        tbl[3] = '{9999,  1'b1, 5'b00100, {SB, S9, S9, S9, S9}, 1'b0};
        tbl[4] = '{10000, 1'b1, 5'b10001, {S1, S0, S0, S0, S0}, 1'b1};
        tbl[5] = '{1005,  1'b1, 5'b01010, {SB, S1, S0, S0, S5}, 1'b0};
        tbl[6] = '{0,     1'b1, 5'b11111, {SB, SB, SB, SB, S0}, 1'b0};
        tbl[7] = '{0,     1'b0, 5'b00000, {S0, S0, S0, S0, S0}, 1'b0};

        // Reset held for five clocks
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_an", {27'd0, an}, 32'h1f);
        check("rst_an4", {28'd0, an4}, 32'hf);
        check("rst_sseg", {25'd0, sseg}, 32'h7f);
        check("rst_dp", {31'd0, dp}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("first_anode", {27'd0, an}, 32'h1e);
        check("first_sseg", {25'd0, sseg}, {25'd0, S0});
        check("first_anode4", {28'd0, an4}, 32'he);

        // Conversion time for 4321
        @(negedge clk);
        num = 16'd4321;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("busy_len", cnt, 17);
        check_scan(4321, 1'b0, 5'b00000);

        // num changes mid-conversion: 100 must commit intact, then 200
        @(negedge clk);
        num = 16'd100;
        repeat (5) @(negedge clk);
        check("busy_mid", {31'd0, busy}, 1);
        num = 16'd200;
        i = 0;
        while (busy && i < 50) begin
            @(negedge clk);
            i++;
        end
        gap = 0;
        while (!busy && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("reconvert_gap", gap, 1);
        i = 0;
        while (busy && i < 50) begin
            k = an_index(an, 5);
            if (k >= 0) check("hold_100", {25'd0, sseg}, {25'd0, exp_seg(100, k, 1'b0, 5)});
            @(negedge clk);
            i++;
        end
        settle();
        check_scan(200, 1'b0, 5'b00000);

        // Reset in the middle of a conversion aborts it
        @(negedge clk);
        num = 16'd12345;
        repeat (4) @(negedge clk);
        check("busy_pre_rst", {31'd0, busy}, 1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_an", {27'd0, an}, 32'h1f);
        check("rst_mid_sseg", {25'd0, sseg}, 32'h7f);
        rst = 1'b1;
        @(negedge clk);
        check("restart_busy", {31'd0, busy}, 1);
        settle();
        check_scan(12345, 1'b0, 5'b00000);

        // Hand-derived vectors
        for (int t = 0; t < 8; t++) begin
            apply(tbl[t].v, tbl[t].blz, tbl[t].mask);
            for (int c = 0; c < 2 * 5 * PS; c++) begin
                @(negedge clk);
                k = an_index(an, 5);
                check("tbl_onehot", {31'd0, k >= 0}, 1);
                if (k >= 0) begin
                    check("tbl_sseg", {25'd0, sseg}, {25'd0, tbl[t].seg[k]});
                    check("tbl_dp", {31'd0, dp}, {31'd0, ~tbl[t].mask[k]});
                end
                check("tbl_ovf4", {31'd0, overflow4}, {31'd0, tbl[t].ovf4});
                if (tbl[t].ovf4) begin
                    check("tbl_dash4", {25'd0, sseg4}, {25'd0, SD});
                    check("tbl_dp4_off", {31'd0, dp4}, 1);
                end
            end
        end

        // Randomised values against the reference
        for (int r = 0; r < 24; r++) begin
            v    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 999))
                                               : int'($urandom_range(0, 65535));
            blz  = 1'($urandom_range(0, 1));
            mask = 5'($urandom_range(0, 31));
            apply(v, blz, mask);
            check_scan(v, blz, mask);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
